spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares one SPI master engine among NREQ requesters, each addressing its own slave.
- Arbitrates round-robin and latches the winner's tx byte and mode/baud settings (spcon, spibr).
- Sequences the winner's chip select with programmable setup, hold and inter-transfer gap timing.
- Starts the engine, waits for completion with a watchdog, and returns the received byte with a per-requester done or error pulse.

Parameters:
- NREQ, 4, number of requesters and slave-select lines (2..8).
- CS_SETUP, 2, clk cycles between ssn assertion and engine start (>=1).
- CS_HOLD, 2, clk cycles between engine done and ssn deassertion (>=1).
- GAP, 1, idle clk cycles after ssn deassertion before the next arbitration (>=0).
- TIMEOUT, 4096, max clk cycles in XFER before abort (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester level request; held until gnt.
- req_tx  in  8*NREQ  tx byte, slice i belongs to requester i.
- req_spcon  in  8*NREQ  SPI control byte per requester; bits [2:1] = {cpol, cpha}.
- req_spibr  in  8*NREQ  baud-rate byte per requester.
- gnt  out  NREQ  one-cycle onehot pulse; operands of that requester captured this cycle.
- done  out  NREQ  one-cycle onehot pulse; rx_data valid in the same cycle.
- err  out  NREQ  one-cycle onehot pulse on watchdog abort.
- rx_data  out  8  received byte of the last completed transfer; held until the next completion.
- ssn_o  out  NREQ  active-low slave selects, at most one low.
- m_start  out  1  one-cycle start pulse to the master engine.
- m_data  out  8  tx byte to the engine, stable from SETUP through HOLD.
- m_spcon  out  8  control byte to the engine, stable from SETUP through HOLD.
- m_spibr  out  8  baud byte to the engine, stable from SETUP through HOLD.
- m_done  in  1  engine completion pulse.
- m_rx_data  in  8  engine received byte, valid when m_done=1.

Behaviour:
- Reset values: state=IDLE, rr pointer=0, gnt=0, done=0, err=0, rx_data=0, ssn_o=all 1, m_start=0, m_data/m_spcon/m_spibr=0.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. GAP is skipped when GAP=0.
- IDLE arbitration:
  - Scan req starting at index ptr, wrapping modulo NREQ; first set bit wins.
  - In that cycle: gnt[w]=1, capture req_tx/spcon/spibr slice w into m_* registers, store w.
  - Next cycle: state=SETUP, ssn_o[w]=0, ptr=(w+1) mod NREQ.
  - No req set: stay in IDLE; ptr unchanged.
- Requester obligations and grant rules:
  - Requester drops req the cycle after gnt, or holds it to queue another transfer.
  - A req that falls before gnt is simply not seen; no error.
  - Only IDLE grants.
- SETUP: counter runs 0..CS_SETUP-1. On the last count, m_start=1 for exactly one cycle; next state XFER.
- XFER: watchdog counts from 0.
  - m_done=1: rx_data<=m_rx_data; next state HOLD.
  - Watchdog reaches TIMEOUT-1 without m_done: err[w] pulse, rx_data unchanged; next state HOLD (abort still honours hold).
  - m_done outside XFER is ignored.
- HOLD: counts CS_HOLD cycles, then ssn_o[w]=1. In the same cycle done[w] pulses (omitted if err already pulsed). Next state GAP.
- GAP: counts GAP cycles of ssn all-high; then IDLE.
- Latency: gnt to m_start = CS_SETUP cycles. m_done to done = CS_HOLD+1 cycles. gnt-to-gnt for back-to-back transfers = 1+CS_SETUP+xfer+CS_HOLD+GAP+1.
- Simultaneous events:
  - req rising during non-IDLE states is queued by level.
  - All req set: strict round-robin, no requester starved; max wait NREQ-1 transfers.
- Reset at any state: immediate return to reset values. ssn_o all high the cycle after rst is sampled; no done/err emitted for the aborted transfer.
- Invariants:
  - ssn_o onehot-low or all-high.
  - gnt, done, err each at most onehot and never together on the same index.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_SETUP=1, ST_XFER=2, ST_HOLD=3, ST_GAP=4);
  - SPCON bit positions (CPOL=2, CPHA=1);
  - the default timing constants.
- One sub-module is natural: spi_rr_pick, a combinational round-robin priority picker (req, ptr -> onehot win, index, valid), reusable by other arbiters.
- Counters and the FSM stay in the top module.

Test Plan:
- Single req[1]=1, tx=0xA5, spcon=0x04 (CPOL=1, CPHA=0) -> gnt[1] one cycle; m_spcon=0x04 while ssn_o[1] is low; m_start exactly 2 cycles after gnt; engine model returns 0x3C -> done[1] 3 cycles after m_done, rx_data=0x3C; ssn_o=4'b1111 afterwards.
- All 4 req held high continuously -> grant order 0,1,2,3,0; only one ssn_o low at any time; >=1 all-high cycle (GAP) between selects.
- req[2] high during XFER of requester 0 -> requester 2 granted in the first IDLE cycle after GAP; ptr=1 honoured, so 2 is next when 1 is not requesting.
- Engine never asserts m_done (TIMEOUT=16) -> err[w] exactly 16 cycles after XFER entry; no done pulse; ssn_o high after CS_HOLD; next req served normally.
- rst asserted mid-XFER -> next cycle ssn_o=1111, m_start=0, gnt/done/err=0, rx_data=0; a later m_done from the engine is ignored.
- Spurious m_done pulse in IDLE and in SETUP -> no state change, rx_data unchanged.

Source files
------------

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared definitions for the SPI transfer arbiter: FSM state
//               encoding, SPCON bit positions and default timing values.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Bit positions inside the per-requester SPI control byte
  localparam int SPCON_CPOL = 2;
  localparam int SPCON_CPHA = 1;

  // Default timing / sizing
  localparam int DEF_NREQ     = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_GAP      = 1;
  localparam int DEF_TIMEOUT  = 4096;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_pick
// Description : Combinational round-robin priority picker. Scans req starting
//               at index ptr, wrapping modulo NREQ; the first set bit wins.
// Ports       : req   - request vector
//               ptr   - index with highest priority this cycle
//               win   - onehot winner (zero when nothing requested)
//               idx   - binary index of the winner
//               valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int          pos;
  logic [IW-1:0] w_pos;

  // Walk from the farthest offset down to offset 0 so that the closest
  // requester to ptr is written last and therefore wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    w_pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos   = (int'(ptr) + k) % NREQ;
      w_pos = IW'(pos);
      if (req[w_pos]) begin
        valid = 1'b1;
        idx   = w_pos;
      end
    end
    if (valid) win[idx] = 1'b1;
  end

endmodule : spi_rr_pick
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_arbiter
// Description : Shares one SPI master engine among NREQ requesters. Grants
//               round-robin, latches the winner's operands, frames the
//               transfer with chip-select setup/hold/gap timing, guards the
//               engine with a watchdog and returns rx data with done/err.
// Ports       : clk, rst                   - clock, sync active-high reset
//               req/req_tx/req_spcon/req_spibr - requester side
//               gnt/done/err/rx_data        - per-requester results
//               ssn_o                       - active-low slave selects
//               m_start/m_data/m_spcon/m_spibr/m_done/m_rx_data - engine side
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int GAP      = DEF_GAP,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_tx,
  input  logic [8*NREQ-1:0] req_spcon,
  input  logic [8*NREQ-1:0] req_spibr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rx_data,
  output logic [NREQ-1:0]   ssn_o,
  output logic              m_start,
  output logic [7:0]        m_data,
  output logic [7:0]        m_spcon,
  output logic [7:0]        m_spibr,
  input  logic              m_done,
  input  logic [7:0]        m_rx_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One shared counter serves every timed state; size it for the longest.
  localparam int CW = $clog2(TIMEOUT + CS_SETUP + CS_HOLD + GAP + 2);

  localparam logic [CW-1:0] c_setup_last = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] c_to_last    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_hold_rel   = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] c_hold_end   = CW'(CS_HOLD);
  localparam logic [CW-1:0] c_gap_last   = CW'((GAP > 0) ? (GAP - 1) : 0);

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_sel;
  logic            r_abort;

  logic [NREQ-1:0] w_win;
  logic [IW-1:0]   w_idx;
  logic            w_valid;
  logic [IW-1:0]   w_ptr_next;
  logic            w_grant;
  logic            w_timeout;
  logic            w_hold_rel;

  spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .win   (w_win),
    .idx   (w_idx),
    .valid (w_valid)
  );

  assign w_ptr_next = (w_idx == IW'(NREQ - 1)) ? '0 : (w_idx + IW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    gnt          = '0;
    m_start      = 1'b0;
    w_grant      = 1'b0;
    w_timeout    = 1'b0;
    w_hold_rel   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant      = 1'b1;
          gnt          = w_win;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == c_setup_last) begin
          m_start      = 1'b1;
          w_state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (m_done) begin
          w_state_next = ST_HOLD;
        end else if (r_cnt == c_to_last) begin
          w_timeout    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // ssn/done are registered on the last hold count so both become
        // visible together in the extra HOLD cycle that follows.
        if (r_cnt == c_hold_rel) w_hold_rel = 1'b1;
        if (r_cnt == c_hold_end) w_state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_cnt == c_gap_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Combinational strobes must stay quiet while reset is being sampled.
    if (rst) begin
      gnt     = '0;
      m_start = 1'b0;
      w_grant = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_abort <= 1'b0;
      done    <= '0;
      err     <= '0;
      rx_data <= '0;
      ssn_o   <= '1;
      m_data  <= '0;
      m_spcon <= '0;
      m_spibr <= '0;
    end else begin
      done <= '0;
      err  <= '0;

      if (r_state == ST_IDLE || w_state_next != r_state) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + CW'(1);

      if (w_grant) begin
        m_data  <= req_tx   [{w_idx, 3'b000} +: 8];
        m_spcon <= req_spcon[{w_idx, 3'b000} +: 8];
        m_spibr <= req_spibr[{w_idx, 3'b000} +: 8];
        r_sel   <= w_win;
        r_ptr   <= w_ptr_next;
        ssn_o   <= ~w_win;
        r_abort <= 1'b0;
      end

      if (r_state == ST_XFER && m_done) rx_data <= m_rx_data;

      if (w_timeout) begin
        err     <= r_sel;
        r_abort <= 1'b1;
      end

      if (w_hold_rel) begin
        ssn_o <= '1;
        done  <= r_abort ? '0 : r_sel;
      end
    end
  end

endmodule : spi_xfer_arbiter
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_arbiter
// Description : Directed self-checking bench for spi_xfer_arbiter with a
//               behavioural SPI engine and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [31:0]     req_tx = '0, req_spcon = '0, req_spibr = '0;
  logic [3:0]      gnt, done, err, ssn_o;
  logic [7:0]      rx_data, m_data, m_spcon, m_spibr;
  logic            m_start;
  logic            m_done = 1'b0;
  logic [7:0]      m_rx_data = '0;

  spi_xfer_arbiter #(
    .NREQ(NREQ), .CS_SETUP(2), .CS_HOLD(2), .GAP(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_tx(req_tx), .req_spcon(req_spcon),
    .req_spibr(req_spibr), .gnt(gnt), .done(done), .err(err),
    .rx_data(rx_data), .ssn_o(ssn_o), .m_start(m_start), .m_data(m_data),
    .m_spcon(m_spcon), .m_spibr(m_spibr), .m_done(m_done),
    .m_rx_data(m_rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, passed = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int         eng_lat = 1;
  bit         eng_hang = 1'b0;
  bit         spur = 1'b0;
  int         eng_cnt = 0;
  logic [7:0] eng_cap = '0;

  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (spur) begin
      spur      = 1'b0;
      m_done    = 1'b1;
      m_rx_data = 8'hEE;
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_hang) begin
        m_done    = 1'b1;
        m_rx_data = eng_cap;
      end
    end
    if (m_start) begin
      eng_cnt = eng_lat;
      eng_cap = m_data ^ 8'h99;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int         idx;
    logic [7:0] rx;
    bit         is_err;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] exp_last_rx = '0;
  logic [3:0] prev_ssn = 4'hF;
  int         last_mdone_cyc = 0;

  always @(negedge clk) begin
    if (m_done) last_mdone_cyc = cyc;
    if (!rst) begin
      if (|gnt || |done || |err) begin
        check("onehot_events", 32'({$onehot0(gnt), $onehot0(done), $onehot0(err)}), 32'h7);
        check("no_overlap", 32'((gnt & done) | (gnt & err) | (done & err)), 32'h0);
      end
      if (ssn_o != prev_ssn) begin
        check("ssn_shape", 32'(ssn_o == 4'hF || $onehot(~ssn_o)), 32'd1);
        check("ssn_no_switch", 32'(prev_ssn != 4'hF && ssn_o != 4'hF), 32'd0);
        prev_ssn = ssn_o;
      end
      if (|done || |err) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'({done, err}), 32'h0);
        end else begin
          e = sb.pop_front();
          check(e.is_err ? "err_idx" : "done_idx", 32'(e.is_err ? err : done), 32'(4'b0001 << e.idx));
          check("result_kind", 32'(e.is_err ? done : err), 32'h0);
          if (!e.is_err) exp_last_rx = e.rx;
          check("rx_data", 32'(rx_data), 32'(exp_last_rx));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ev_hit(input int which);
    case (which)
      0:       return |gnt;
      1:       return m_start;
      2:       return |done;
      3:       return |err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int limit, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      hit = ev_hit(which);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_slice(input int i, input logic [7:0] tx, input logic [7:0] sp, input logic [7:0] br);
    req_tx[8*i +: 8]    = tx;
    req_spcon[8*i +: 8] = sp;
    req_spibr[8*i +: 8] = br;
  endtask

  task automatic push_done(input int i);
    sb.push_back('{idx: i, rx: req_tx[8*i +: 8] ^ 8'h99, is_err: 1'b0});
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g, s;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_ssn", 32'(ssn_o), 32'hF);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rx", 32'(rx_data), 32'h0);
    check("rst_start", 32'(m_start), 32'h0);
    check("rst_mdata", 32'({m_data, m_spcon, m_spibr}), 32'h0);
    step();
    rst = 1'b0;

    // Single transfer from requester 1, CPOL=1 CPHA=0
    set_slice(1, 8'hA5, 8'h04, 8'h11);
    push_done(1);
    req = 4'b0010;
    wait_ev(0, 10, "t1_gnt_seen");
    check("t1_gnt", 32'(gnt), 32'h2);
    g = cyc;
    step();
    req = '0;
    wait_ev(1, 10, "t1_start_seen");
    check("t1_start_lat", 32'(cyc - g), 32'd2);
    check("t1_ssn_sel", 32'(ssn_o), 32'hD);
    check("t1_spcon", 32'(m_spcon), 32'h04);
    check("t1_data", 32'(m_data), 32'hA5);
    check("t1_spibr", 32'(m_spibr), 32'h11);
    step();
    check("t1_start_pulse", 32'(m_start), 32'h0);
    wait_ev(2, 20, "t1_done_seen");
    check("t1_done_lat", 32'(cyc - last_mdone_cyc), 32'd3);
    check("t1_rx", 32'(rx_data), 32'h3C);
    check("t1_ssn_idle", 32'(ssn_o), 32'hF);

    // All requesters held high: strict round-robin from pointer 0
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    exp_last_rx = '0;
    for (int i = 0; i < 4; i++) set_slice(i, 8'(16 * i + 1), 8'(i << 1), 8'(i + 2));
    push_done(0); push_done(1); push_done(2); push_done(3); push_done(0);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ev(0, 20, "t2_gnt_seen");
      check("t2_order", 32'(oh2i(gnt)), 32'(k % 4));
      if (k > 0) check("t2_period", 32'(cyc - g), 32'd8);
      g = cyc;
      step();
      if (k == 4) req = '0;
    end
    drain(60);

    // Request from 2 arriving while 0 is mid-transfer (pointer now 1)
    eng_lat = 3;
    push_done(0);
    req = 4'b0001;
    wait_ev(0, 20, "t3_gnt0_seen");
    check("t3_gnt0", 32'(gnt), 32'h1);
    g = cyc;
    step();
    req = '0;
    wait_ev(1, 10, "t3_start_seen");
    step();
    check("t3_ssn_xfer", 32'(ssn_o), 32'hE);
    req = 4'b0100;
    push_done(2);
    wait_ev(0, 30, "t3_gnt2_seen");
    check("t3_gnt2", 32'(gnt), 32'h4);
    check("t3_period", 32'(cyc - g), 32'd10);
    step();
    req = '0;
    drain(40);

    // Engine never completes: watchdog abort
    eng_lat = 1;
    eng_hang = 1'b1;
    sb.push_back('{idx: 3, rx: 8'h00, is_err: 1'b1});
    req = 4'b1000;
    wait_ev(0, 20, "t4_gnt_seen");
    check("t4_gnt", 32'(gnt), 32'h8);
    step();
    req = '0;
    wait_ev(1, 10, "t4_start_seen");
    s = cyc;
    wait_ev(3, 40, "t4_err_seen");
    check("t4_err_lat", 32'(cyc - s), 32'd17);
    check("t4_ssn_at_err", 32'(ssn_o), 32'h7);
    step();
    step();
    check("t4_ssn_release", 32'(ssn_o), 32'hF);
    check("t4_no_done", 32'(done), 32'h0);
    eng_hang = 1'b0;
    set_slice(1, 8'h5A, 8'h02, 8'h07);
    push_done(1);
    req = 4'b0010;
    wait_ev(0, 20, "t4_next_gnt_seen");
    check("t4_next_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    drain(40);

    // Reset in the middle of a transfer
    eng_lat = 5;
    req = 4'b0001;
    wait_ev(0, 20, "t5_gnt_seen");
    step();
    req = '0;
    wait_ev(1, 10, "t5_start_seen");
    s = cyc;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_last_rx = '0;
    @(negedge clk);
    check("t5_ssn", 32'(ssn_o), 32'hF);
    check("t5_start", 32'(m_start), 32'h0);
    check("t5_events", 32'({gnt, done, err}), 32'h0);
    check("t5_rx", 32'(rx_data), 32'h0);
    repeat (6) step();
    check("t5_engine_fired", 32'(last_mdone_cyc > s), 32'd1);
    check("t5_rx_after", 32'(rx_data), 32'h0);
    check("t5_ssn_after", 32'(ssn_o), 32'hF);

    // Spurious engine completion in IDLE and in SETUP
    eng_lat = 1;
    @(negedge clk);
    spur = 1'b1;
    step();
    step();
    @(negedge clk);
    check("t6_idle_rx", 32'(rx_data), 32'h0);
    check("t6_idle_ssn", 32'(ssn_o), 32'hF);
    step();
    push_done(2);
    req = 4'b0100;
    wait_ev(0, 20, "t6_gnt_seen");
    check("t6_gnt", 32'(gnt), 32'h4);
    g = cyc;
    spur = 1'b1;
    step();
    req = '0;
    @(negedge clk);
    check("t6_setup_ssn", 32'(ssn_o), 32'hB);
    check("t6_setup_rx", 32'(rx_data), 32'h0);
    wait_ev(1, 10, "t6_start_seen");
    check("t6_start_lat", 32'(cyc - g), 32'd2);
    drain(40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_spi_xfer_arbiter
`default_nettype wire
